// File: rtl/turn_sequencer_if.sv
// Turn sequencer signal bundle: game inputs from board/card logic and the
// sequencer's state and strobe outputs. The master side drives game inputs,
// the slave side is the sequencer itself.
interface turn_sequencer_if;
    logic       start;
    logic       flip_valid;
    logic [3:0] card_id;
    logic [3:0] target_id;
    logic       win;
    logic [2:0] q;
    logic       statecombo_next_turn;
    logic       move_pulse;
    logic       hide_cards;
    logic [3:0] streak;
    logic       game_over;

    modport master (
        output start, flip_valid, card_id, target_id, win,
        input  q, statecombo_next_turn, move_pulse, hide_cards, streak, game_over
    );

    modport slave (
        input  start, flip_valid, card_id, target_id, win,
        output q, statecombo_next_turn, move_pulse, hide_cards, streak, game_over
    );
endinterface

// File: rtl/turn_sequencer.sv
// Game-flow FSM for Chicken Cha-Cha-Cha. Latches each flipped card, compares it
// with the tile ahead of the current chicken, pulses move_pulse on a match and,
// on a miss, holds for HOLD_CYCLES before strobing statecombo_next_turn.
// Optional macro STREAK_LIMIT_EN forces a turn change after MAX_STREAK matches.
module turn_sequencer #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int HOLD_W      = 26,
    parameter int MAX_STREAK  = 8
) (
    input logic             clk,
    input logic             rst_n,
    turn_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        WAIT_FLIP = 3'b001,
        COMPARE   = 3'b010,
        MOVE      = 3'b011,
        MISS_HOLD = 3'b100,
        NEXT_TURN = 3'b101,
        CHECK_WIN = 3'b110,
        GAME_OVER = 3'b111
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Elaboration-time sanity checks on the configuration.
    if ((64'd1 << HOLD_W) <= 64'(HOLD_CYCLES)) begin : g_bad_hold_w
        $error("HOLD_W too narrow for HOLD_CYCLES");
    end
    if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_max_streak
        $error("MAX_STREAK must be within 1..15");
    end

`ifdef STREAK_LIMIT_EN
    localparam logic [3:0] STREAK_CAP = 4'(MAX_STREAK);
`endif

    state_t            state;
    logic [3:0]        card;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        streak;
    logic              move_pulse;
    logic              next_turn;
    logic              hide_cards;
    logic              game_over;

    assign bus.q                    = state;
    assign bus.statecombo_next_turn = next_turn;
    assign bus.move_pulse           = move_pulse;
    assign bus.hide_cards           = hide_cards;
    assign bus.streak               = streak;
    assign bus.game_over            = game_over;

    // State register with registered strobes; each strobe is set on the edge
    // that enters its state, so it is high for exactly that state's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            card       <= '0;
            hold_cnt   <= '0;
            streak     <= '0;
            move_pulse <= 1'b0;
            next_turn  <= 1'b0;
            hide_cards <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            move_pulse <= 1'b0;
            next_turn  <= 1'b0;
            hide_cards <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= WAIT_FLIP;
                        streak <= '0;
                    end
                end
                WAIT_FLIP: begin
                    if (bus.flip_valid) begin
                        card  <= bus.card_id;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (card == bus.target_id) begin
                        state      <= MOVE;
                        move_pulse <= 1'b1;
                    end else begin
                        state    <= MISS_HOLD;
                        hold_cnt <= '0;
                    end
                end
                MOVE: begin
                    if (streak != 4'hF) begin
                        streak <= streak + 4'd1;
                    end
                    state <= CHECK_WIN;
                end
                CHECK_WIN: begin
                    // The board has had one cycle after move_pulse to update win.
                    if (bus.win) begin
                        state     <= GAME_OVER;
                        game_over <= 1'b1;
                    end
`ifdef STREAK_LIMIT_EN
                    else if (streak == STREAK_CAP) begin
                        state      <= NEXT_TURN;
                        next_turn  <= 1'b1;
                        hide_cards <= 1'b1;
                    end else begin
                        state <= WAIT_FLIP;
                    end
`else
                    else begin
                        state <= WAIT_FLIP;
                    end
`endif
                end
                MISS_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= NEXT_TURN;
                        next_turn  <= 1'b1;
                        hide_cards <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                NEXT_TURN: begin
                    streak <= '0;
                    state  <= WAIT_FLIP;
                end
                GAME_OVER: begin
                    if (bus.start) begin
                        state      <= WAIT_FLIP;
                        streak     <= '0;
                        hide_cards <= 1'b1;
                        game_over  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed testbench for turn_sequencer with HOLD_CYCLES=4 and MAX_STREAK=2.
// Honors STREAK_LIMIT_EN when compiled with the macro defined.
module tb_turn_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   nt_count;
    int   exp_nt;
    int   exp_streak_pre_miss;

    turn_sequencer_if bus ();

    turn_sequencer #(
        .HOLD_CYCLES(4),
        .HOLD_W     (3),
        .MAX_STREAK (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count next-turn strobes sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.statecombo_next_turn) nt_count++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        nt_count = 0;
        bus.start      = 1'b0;
        bus.flip_valid = 1'b0;
        bus.card_id    = 4'd0;
        bus.target_id  = 4'd0;
        bus.win        = 1'b0;
        rst_n          = 1'b0;
        repeat (2) tick();

        check("rst_q", int'(bus.q), 0);
        check("rst_streak", int'(bus.streak), 0);
        check("rst_nt", int'(bus.statecombo_next_turn), 0);
        check("rst_move", int'(bus.move_pulse), 0);
        check("rst_hide", int'(bus.hide_cards), 0);
        check("rst_go", int'(bus.game_over), 0);

        rst_n = 1'b1;
        tick();
        check("idle_hold", int'(bus.q), 0);

        // start together with flip_valid in IDLE: flip must be ignored
        bus.start = 1'b1; bus.flip_valid = 1'b1; bus.card_id = 4'd3;
        tick();
        bus.start = 1'b0; bus.flip_valid = 1'b0;
        check("start_q", int'(bus.q), 1);
        tick();
        check("idle_flip_ignored", int'(bus.q), 1);

        // First match: card 3 vs target 3
        bus.target_id = 4'd3; bus.card_id = 4'd3; bus.flip_valid = 1'b1;
        tick();
        bus.flip_valid = 1'b0; bus.card_id = 4'd9;
        check("m1_cmp_q", int'(bus.q), 2);
        check("m1_cmp_move", int'(bus.move_pulse), 0);
        tick();
        check("m1_move_q", int'(bus.q), 3);
        check("m1_move_pulse", int'(bus.move_pulse), 1);
        tick();
        check("m1_cw_q", int'(bus.q), 6);
        check("m1_cw_move", int'(bus.move_pulse), 0);
        check("m1_streak", int'(bus.streak), 1);
        tick();
        check("m1_back_q", int'(bus.q), 1);
        check("m1_no_nt", nt_count, 0);

        // start during WAIT_FLIP is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("wf_start_q", int'(bus.q), 1);
        check("wf_start_streak", int'(bus.streak), 1);

        // Second match
        bus.card_id = 4'd3; bus.flip_valid = 1'b1;
        tick();
        bus.flip_valid = 1'b0;
        tick();
        check("m2_move_pulse", int'(bus.move_pulse), 1);
        tick();
        check("m2_streak", int'(bus.streak), 2);
        tick();
`ifdef STREAK_LIMIT_EN
        check("lim_q", int'(bus.q), 5);
        check("lim_nt", int'(bus.statecombo_next_turn), 1);
        check("lim_hide", int'(bus.hide_cards), 1);
        tick();
        check("lim_back_q", int'(bus.q), 1);
        check("lim_streak", int'(bus.streak), 0);
        exp_nt = 1;
        exp_streak_pre_miss = 0;
`else
        check("m2_back_q", int'(bus.q), 1);
        check("m2_keep_streak", int'(bus.streak), 2);
        exp_nt = 0;
        exp_streak_pre_miss = 2;
`endif

        // Miss: card 5 vs target 2, with a flip and a start during the hold
        bus.card_id = 4'd5; bus.target_id = 4'd2; bus.flip_valid = 1'b1;
        tick();
        bus.flip_valid = 1'b0;
        check("miss_cmp_q", int'(bus.q), 2);
        tick();
        check("miss_hold_q0", int'(bus.q), 4);
        for (int i = 1; i < 4; i++) begin
            if (i == 1) begin bus.flip_valid = 1'b1; bus.card_id = 4'd2; end
            if (i == 2) bus.start = 1'b1;
            tick();
            bus.flip_valid = 1'b0;
            bus.start = 1'b0;
            check($sformatf("miss_hold_q%0d", i), int'(bus.q), 4);
        end
        tick();
        check("nt_q", int'(bus.q), 5);
        check("nt_strobe", int'(bus.statecombo_next_turn), 1);
        check("nt_hide", int'(bus.hide_cards), 1);
        check("nt_streak", int'(bus.streak), exp_streak_pre_miss);
        tick();
        check("post_nt_q", int'(bus.q), 1);
        check("post_nt_streak", int'(bus.streak), 0);
        check("post_nt_strobe", int'(bus.statecombo_next_turn), 0);
        check("post_nt_hide", int'(bus.hide_cards), 0);
        exp_nt = exp_nt + 1;
        check("nt_count_miss", nt_count, exp_nt);
        repeat (3) tick();
        check("no_replay_q", int'(bus.q), 1);

        // Match followed by win -> GAME_OVER
        bus.card_id = 4'd7; bus.target_id = 4'd7; bus.flip_valid = 1'b1;
        tick();
        bus.flip_valid = 1'b0;
        tick();
        bus.win = 1'b1;
        tick();
        check("win_cw_q", int'(bus.q), 6);
        check("win_streak", int'(bus.streak), 1);
        tick();
        check("go_q", int'(bus.q), 7);
        check("go_flag", int'(bus.game_over), 1);
        bus.win = 1'b0;
        bus.flip_valid = 1'b1;
        tick();
        bus.flip_valid = 1'b0;
        check("go_flip_ignored", int'(bus.q), 7);
        tick();
        check("go_stay", int'(bus.game_over), 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_q", int'(bus.q), 1);
        check("restart_streak", int'(bus.streak), 0);
        check("restart_hide", int'(bus.hide_cards), 1);
        check("restart_go", int'(bus.game_over), 0);
        tick();
        check("restart_hide_end", int'(bus.hide_cards), 0);

        // Reset asserted during MISS_HOLD
        bus.card_id = 4'd1; bus.target_id = 4'd2; bus.flip_valid = 1'b1;
        tick();
        bus.flip_valid = 1'b0;
        tick();
        tick();
        check("rmid_hold_q", int'(bus.q), 4);
        #1 rst_n = 1'b0;
        #1;
        check("rmid_q", int'(bus.q), 0);
        check("rmid_nt", int'(bus.statecombo_next_turn), 0);
        check("rmid_hide", int'(bus.hide_cards), 0);
        check("rmid_go", int'(bus.game_over), 0);
        repeat (6) tick();
        check("rmid_nt_count", nt_count, exp_nt);
        rst_n = 1'b1;
        tick();
        check("rmid_after_q", int'(bus.q), 0);
        check("rmid_after_nt_count", nt_count, exp_nt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
